pwm_peripheral: RTL
===================

Name: pwm_peripheral

Overview:
- 16-channel PWM/static output stage directly downstream of the SPI register bank.
- Consumes en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle and drives 16 output pins.
- Each channel is one of: forced low, static high, or PWM at one shared duty cycle.
- A shared prescaler plus an 8-bit period counter form the time base.

Parameters:
- CLK_DIV, default 3000: clk cycles per PWM counter step; legal range >= 1.
- NUM_CH, default 16: channel count; fixed to 16 in this revision.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- en_reg_out_7_0  in  8  output enable, channels 7..0
- en_reg_out_15_8  in  8  output enable, channels 15..8
- en_reg_pwm_7_0  in  8  PWM mode select, channels 7..0
- en_reg_pwm_15_8  in  8  PWM mode select, channels 15..8
- pwm_duty_cycle  in  8  shared duty, 0x00 = 0 %, 0xFF = 100 %
- out  out  16  channel outputs, registered
- period_start  out  1  one-clk pulse when the period counter wraps to 0

Behaviour:
- Reset (rst_n=0 at posedge clk): prescaler=0, pwm_cnt=0, out=16'h0000, period_start=0, shadow registers=0. Reset overrides everything, including a reset asserted mid-period.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps.
  - tick = (prescaler == CLK_DIV-1).
  - If CLK_DIV=1, tick is high every cycle.
- Period counter pwm_cnt (8 bit):
  - Advances only on tick; range 0..254.
  - On tick with pwm_cnt==254 it wraps to 0.
  - Never reaches 255, so the period is 255*CLK_DIV clk cycles.
- period_start is registered, high for exactly one clk: the cycle after the tick that wraps pwm_cnt 254->0.
- PWM signal: pwm_sig = (pwm_cnt < duty_eff), an unsigned 8-bit compare.
  - duty 0: never high.
  - duty 255: always high.
  - duty d: high for d*CLK_DIV clk per period.
- Channel i, with en_out_i / en_pwm_i the concatenated 16-bit enable vectors (bit 15 from *_15_8[7]):
  - en_out_i=0: out[i] next = 0, regardless of en_pwm_i.
  - en_out_i=1, en_pwm_i=0: out[i] next = 1.
  - en_out_i=1, en_pwm_i=1: out[i] next = pwm_sig.
- Latency: out is registered and reflects the counter and inputs of the previous clk, i.e. 1 clk after any change in pwm_cnt or in the effective inputs.
- Input changes are treated as asynchronous to the period; no glitch filtering beyond the register stage, except as defined under Optional Feature.
- All channels share one time base; PWM rising edges are phase-aligned across channels.

Optional Feature:
- Macro: PWM_SHADOW_UPDATE_EN.
- Defined:
  - duty_eff, en_out_eff and en_pwm_eff come from shadow registers.
  - Shadows load on the tick that wraps pwm_cnt 254->0, the same edge that produces period_start.
  - After reset, shadows are 0, so out stays 0 until the first wrap.
  - A mid-period input change never alters the current period.
- Undefined: effective values are the live inputs, with no shadow flops.

Decomposition:
- Package pwm_pkg holds:
  - PWM_CNT_MAX = 8'd254
  - PWM_NUM_CH = 16
  - default CLK_DIV
  - a localparam function for prescaler width, clog2(CLK_DIV) with minimum 1.
- One sub-module, pwm_timebase: prescaler, pwm_cnt, tick, period_start.
- Channel mux and out register stay in the top module.

Test Plan (CLK_DIV=4, period=1020 clk):
- Reset: rst_n low for 1 clk mid-period with out[3]=1 -> next clk out=0, pwm_cnt=0, prescaler=0; counting resumes from 0.
- Static, non-shadow build: en_out=16'h0001, en_pwm=0 -> out[0]=1 one clk later and stays 1; out[15:1]=0.
- PWM half: duty=128, en_out=en_pwm=16'h8000 -> out[15] high 512 clk, low 508 clk, repeating; period_start every 1020 clk.
- Extremes: duty=0 -> out[15]=0 continuously; duty=255 -> out[15]=1 continuously; en_out=0, en_pwm=16'hFFFF, duty=255 -> out=0.
- Shadow build: duty changes 64->192 mid-period -> current period high 256 clk; next period high 768 clk, starting at the cycle after period_start.
- CLK_DIV=1: duty=1 -> high exactly 1 clk per 255-clk period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
// Contents: period counter limit, channel count, default prescaler divide,
// and a prescaler width helper (clog2 with a floor of 1 bit).
package pwm_pkg;

   localparam logic [7:0] PWM_CNT_MAX     = 8'd254;
   localparam int         PWM_NUM_CH      = 16;
   localparam int         PWM_CLK_DIV_DEF = 3000;

   // A divide of 1 still needs a 1-bit prescaler so the register exists.
   function automatic int presc_width(input int div);
      int w;
      w = $clog2(div);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM time base: prescaler plus 8-bit period counter (0..254).
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   pwm_cnt       current period counter value
//   wrap          combinational, high on the tick that takes pwm_cnt 254->0
//   period_start  registered one-clk pulse following the wrapping tick
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = PWM_CLK_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] pwm_cnt,
   output logic       wrap,
   output logic       period_start
);

   localparam int             PW         = presc_width(CLK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] prescaler;
   logic          tick;

   // With CLK_DIV=1 the prescaler sits at 0 and tick is permanently high.
   assign tick = (prescaler == PRESC_LAST);
   assign wrap = tick && (pwm_cnt == PWM_CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler    <= '0;
         pwm_cnt      <= '0;
         period_start <= 1'b0;
      end else begin
         prescaler    <= tick ? '0 : prescaler + 1'b1;
         if (tick)
            pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
         period_start <= wrap;
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM / static output stage fed by the SPI register bank.
// Each channel is forced low, static high, or PWM at the shared duty.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   en_reg_out_7_0/_15_8            output enables
//   en_reg_pwm_7_0/_15_8            PWM mode selects
//   pwm_duty_cycle                  shared duty (0x00 = 0 %, 0xFF = 100 %)
//   out                             registered channel outputs
//   period_start                    one-clk pulse when the period restarts
// Build option: define PWM_SHADOW_UPDATE_EN to latch duty and enables only at
// the period wrap, so mid-period register writes take effect next period.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = PWM_CLK_DIV_DEF,
   parameter int NUM_CH  = PWM_NUM_CH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        en_reg_out_7_0,
   input  logic [7:0]        en_reg_out_15_8,
   input  logic [7:0]        en_reg_pwm_7_0,
   input  logic [7:0]        en_reg_pwm_15_8,
   input  logic [7:0]        pwm_duty_cycle,
   output logic [NUM_CH-1:0] out,
   output logic              period_start
);

   logic [7:0]        pwm_cnt;
   logic              wrap;
   logic [NUM_CH-1:0] en_out_live, en_pwm_live;
   logic [NUM_CH-1:0] en_out_eff, en_pwm_eff;
   logic [7:0]        duty_eff;
   logic              pwm_sig;

   assign en_out_live = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm_live = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_timebase #(.CLK_DIV(CLK_DIV)) u_tb (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_cnt      (pwm_cnt),
      .wrap         (wrap),
      .period_start (period_start)
   );

`ifdef PWM_SHADOW_UPDATE_EN
   logic [7:0]        duty_sh;
   logic [NUM_CH-1:0] en_out_sh, en_pwm_sh;

   // Load on the same edge that raises period_start, so the new settings
   // govern the period from its very first count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_sh   <= '0;
         en_out_sh <= '0;
         en_pwm_sh <= '0;
      end else if (wrap) begin
         duty_sh   <= pwm_duty_cycle;
         en_out_sh <= en_out_live;
         en_pwm_sh <= en_pwm_live;
      end
   end

   assign duty_eff   = duty_sh;
   assign en_out_eff = en_out_sh;
   assign en_pwm_eff = en_pwm_sh;
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign duty_eff    = pwm_duty_cycle;
   assign en_out_eff  = en_out_live;
   assign en_pwm_eff  = en_pwm_live;
`endif

   // pwm_cnt never reaches 255, so duty 255 keeps the compare true all period.
   assign pwm_sig = (pwm_cnt < duty_eff);

   always_ff @(posedge clk) begin
      if (!rst_n)
         out <= '0;
      else
         out <= en_out_eff & (~en_pwm_eff | {NUM_CH{pwm_sig}});
   end

endmodule
